// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with branch squash and optional fetch timeout.
// Optional feature: define FETCH_TIMEOUT_EN to enable the imem_ack timeout and ERR state.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_cur,
    output logic [15:0] pc_next,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
    state_t state, state_nx;
    logic squash;
    logic [15:0] pending;
    logic timeout_hit;
    logic redirect;
    assign imem_addr = pc_cur;
    assign redirect = squash || branch_taken;
`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign timeout_hit = !imem_ack && (cnt == CW'(TIMEOUT - 1));
    // Counter sits at zero outside REQ, so entering REQ always starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            fetch_err <= 1'b0;
        end else if (state != REQ || imem_ack) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            fetch_err <= fetch_err | timeout_hit;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign fetch_err = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        pc_next = pc_cur;
        if (rst) begin
            pc_next = RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    pc_next = RESET_PC;
                    state_nx = REQ;
                end
                REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_next = branch_taken ? branch_target : squash ? pending : pc_cur + PC_STEP;
                        state_nx = redirect ? REQ : HOLD;
                    end else if (timeout_hit) begin
                        state_nx = ERR;
                    end
                end
                HOLD: begin
                    pc_next = branch_taken ? branch_target : pc_cur;
                    state_nx = (branch_taken || !stall) ? REQ : HOLD;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            instr_valid <= 1'b0;
            instr_out <= '0;
            instr_pc <= '0;
            squash <= 1'b0;
            pending <= '0;
        end else begin
            state <= state_nx;
            if (state == REQ && imem_ack) begin
                squash <= 1'b0;
                if (!redirect) begin
                    instr_out <= imem_rdata;
                    instr_pc <= pc_cur;
                    instr_valid <= 1'b1;
                end
            end else if (state == REQ && branch_taken) begin
                squash <= 1'b1;
                pending <= branch_target;
            end
            if (state == HOLD && (branch_taken || !stall))
                instr_valid <= 1'b0;
        end
    end
endmodule
